// File: rtl/ddma_local_arbiter.sv
// Packet-level round-robin arbiter sharing one router LOCAL input among NUM_REQ
// flit sources; ownership is held for a whole Hermes packet (header, size, payload).
module ddma_local_arbiter #(
  parameter int FLIT_WIDTH = 32,
  parameter int NUM_REQ    = 2,
  parameter int SIZE_WIDTH = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*FLIT_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          tx_o,
  output logic [FLIT_WIDTH-1:0]         data_o,
  input  logic                          credit_i,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          pkt_done_o
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEADER,
    S_SIZE,
    S_PAYLOAD
  } state_t;

  state_t                state_q, state_d;
  logic [PTR_W-1:0]      owner_q, owner_d;
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [SIZE_WIDTH-1:0] remaining_q, remaining_d;
  logic                  pkt_done_q, pkt_done_d;

  logic [FLIT_WIDTH-1:0] owner_data;
  logic                  owner_valid;
  logic                  pick_found;
  logic [PTR_W-1:0]      pick_idx;
  logic                  xfer;

  always_comb begin
    owner_data  = '0;
    owner_valid = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (owner_q == PTR_W'(k)) begin
        owner_data  = req_data_i[k*FLIT_WIDTH +: FLIT_WIDTH];
        owner_valid = req_valid_i[k];
      end
    end
  end

  // Lowest valid index at or after rr_ptr wins; otherwise wrap to the lowest valid index.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid_i[k]) begin
        pick_found = 1'b1;
        pick_idx   = PTR_W'(k);
      end
    end
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid_i[k] && (PTR_W'(k) >= rr_ptr_q)) begin
        pick_idx = PTR_W'(k);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    remaining_d = remaining_q;
    pkt_done_d  = 1'b0;
    tx_o        = 1'b0;
    data_o      = '0;
    req_ready_o = '0;
    grant_o     = '0;
    xfer        = 1'b0;

    if (state_q == S_IDLE) begin
      if (pick_found) begin
        owner_d = pick_idx;
        state_d = S_HEADER;
      end
    end else begin
      tx_o   = owner_valid;
      data_o = owner_data;
      xfer   = owner_valid && credit_i;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (owner_q == PTR_W'(k)) begin
          grant_o[k]     = 1'b1;
          req_ready_o[k] = xfer;
        end
      end

      if (xfer) begin
        case (state_q)
          S_HEADER: state_d = S_SIZE;
          S_SIZE: begin
            remaining_d = owner_data[SIZE_WIDTH-1:0];
            state_d     = (owner_data[SIZE_WIDTH-1:0] == '0) ? S_IDLE : S_PAYLOAD;
          end
          default: begin
            remaining_d = remaining_q - 1'b1;
            if (remaining_q == SIZE_WIDTH'(1)) state_d = S_IDLE;
          end
        endcase
        if (state_d == S_IDLE) begin
          pkt_done_d = 1'b1;
          rr_ptr_d   = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      remaining_q <= '0;
      pkt_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      remaining_q <= remaining_d;
      pkt_done_q  <= pkt_done_d;
    end
  end

  assign pkt_done_o = pkt_done_q;

endmodule
